// File: rtl/l2_arbiter_if.sv
// ============================================================================
// Module      : l2_arbiter_if
// Description : Bus bundle between the I-cache, the D-cache, the L2 arbiter
//               and the downstream L2. Carries the I-cache read port, the
//               D-cache read/write-back port and the downstream L2 port.
//   modport master : cache/L2 environment side (drives requests and L2 data)
//   modport slave  : arbiter side (drives responses and the L2 request)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface l2_arbiter_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
);
  // I-cache port (read only)
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  // D-cache port
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  // Downstream L2 port
  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp
  );

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp
  );
endinterface

`default_nettype wire

// File: rtl/l2_arbiter.sv
// ============================================================================
// Module      : l2_arbiter
// Description : Round-robin arbiter sharing one L2 port between the I-cache
//               and the D-cache. One transaction at a time, no preemption,
//               with saturating performance counters.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : I-cache, D-cache and downstream L2 signals
//   count_reset    : synchronous clear of the three counters
//   i_grant_count  : completed I-cache transactions
//   d_grant_count  : completed D-cache transactions
//   conflict_count : IDLE cycles in which both caches were requesting
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  l2_arbiter_if.slave        bus,
  input  logic               count_reset,
  output logic [15:0]        i_grant_count,
  output logic [15:0]        d_grant_count,
  output logic [15:0]        conflict_count
);

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ZERO = '0;
  localparam logic [LINE_WIDTH-1:0] C_LINE_ZERO = '0;
  localparam logic [15:0]           C_CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant_d;   // 1: D-cache was granted last
  logic        r_l2_read;
  logic        r_l2_write;
  logic [15:0] r_i_grant_cnt;
  logic [15:0] r_d_grant_cnt;
  logic [15:0] r_conflict_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req = bus.i_read;
  assign w_d_req = bus.d_read | bus.d_write;

  // Under contention the side that was not granted last wins.
  assign w_grant_i = w_i_req & (~w_d_req | r_last_grant_d);
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_grant_d);

  // The request type is captured at grant time so a requester dropping its
  // request mid-transaction does not disturb the outstanding L2 access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_grant_d <= 1'b1;
      r_l2_read      <= 1'b0;
      r_l2_write     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_i) begin
            r_state        <= ST_SERVE_I;
            r_last_grant_d <= 1'b0;
            r_l2_read      <= 1'b1;
            r_l2_write     <= 1'b0;
          end else if (w_grant_d) begin
            r_state        <= ST_SERVE_D;
            r_last_grant_d <= 1'b1;
            r_l2_read      <= bus.d_read & ~bus.d_write;
            r_l2_write     <= bus.d_write;
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          // Returning to IDLE guarantees a gap cycle between transactions.
          if (bus.l2_resp) begin
            r_state    <= ST_IDLE;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_l2_read  <= 1'b0;
          r_l2_write <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [15:0] f_count_next(
    input logic [15:0] cnt,
    input logic        clr,
    input logic        inc
  );
    if (clr)                          return 16'd0;
    else if (inc && cnt != C_CNT_MAX) return cnt + 16'd1;
    else                              return cnt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_grant_cnt  <= 16'd0;
      r_d_grant_cnt  <= 16'd0;
      r_conflict_cnt <= 16'd0;
    end else begin
      r_i_grant_cnt  <= f_count_next(r_i_grant_cnt, count_reset,
                                     (r_state == ST_SERVE_I) && bus.l2_resp);
      r_d_grant_cnt  <= f_count_next(r_d_grant_cnt, count_reset,
                                     (r_state == ST_SERVE_D) && bus.l2_resp);
      r_conflict_cnt <= f_count_next(r_conflict_cnt, count_reset,
                                     (r_state == ST_IDLE) && w_i_req && w_d_req);
    end
  end

  // Responses are gated by state, so a resp arriving after a reset-aborted
  // transaction is never forwarded.
  assign bus.i_resp     = (r_state == ST_SERVE_I) & bus.l2_resp;
  assign bus.d_resp     = (r_state == ST_SERVE_D) & bus.l2_resp;
  assign bus.i_rdata    = bus.l2_rdata;
  assign bus.d_rdata    = bus.l2_rdata;
  assign bus.l2_read    = r_l2_read;
  assign bus.l2_write   = r_l2_write;
  assign bus.l2_address = (r_state == ST_SERVE_I) ? bus.i_address :
                          (r_state == ST_SERVE_D) ? bus.d_address : C_ADDR_ZERO;
  assign bus.l2_wdata   = (r_state == ST_SERVE_D) ? bus.d_wdata : C_LINE_ZERO;

  assign i_grant_count  = r_i_grant_cnt;
  assign d_grant_count  = r_d_grant_cnt;
  assign conflict_count = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
// ============================================================================
// Module      : tb_l2_arbiter
// Description : Directed self-checking bench for l2_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l2_arbiter;

  logic        clk;
  logic        rst_n;
  logic        count_reset;
  logic [15:0] i_grant_count;
  logic [15:0] d_grant_count;
  logic [15:0] conflict_count;

  int r_tests;
  int r_fails;

  l2_arbiter_if #(.LINE_WIDTH(128), .ADDR_WIDTH(16)) bus ();

  l2_arbiter #(.LINE_WIDTH(128), .ADDR_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .count_reset    (count_reset),
    .i_grant_count  (i_grant_count),
    .d_grant_count  (d_grant_count),
    .conflict_count (conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    r_tests++;
    if (got !== exp) begin
      r_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] C_A5 = {16{8'hA5}};
  localparam logic [127:0] C_WB = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;

  initial begin
    r_tests = 0;
    r_fails = 0;
    rst_n = 1'b0;
    count_reset = 1'b0;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.l2_rdata = '0; bus.l2_resp = 1'b0;

    // reset state
    #2;
    chk("rst_l2_read", bus.l2_read, 1'b0);
    chk("rst_l2_write", bus.l2_write, 1'b0);
    chk("rst_counters", {i_grant_count, d_grant_count, conflict_count}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single I-cache read, L2 answers in the 4th serve cycle
    bus.i_read = 1'b1; bus.i_address = 16'h3040;
    #1;
    chk("i_idle_no_l2_read", bus.l2_read, 1'b0);
    tick();
    chk("i_l2_read", bus.l2_read, 1'b1);
    chk("i_l2_write", bus.l2_write, 1'b0);
    chk("i_l2_address", bus.l2_address, 16'h3040);
    repeat (3) begin
      chk("i_wait_no_resp", bus.i_resp, 1'b0);
      tick();
    end
    bus.l2_resp = 1'b1; bus.l2_rdata = C_A5;
    #1;
    chk("i_resp", bus.i_resp, 1'b1);
    chk("i_rdata", bus.i_rdata, C_A5);
    chk("i_no_d_resp", bus.d_resp, 1'b0);
    tick();
    bus.i_read = 1'b0; bus.l2_resp = 1'b0;
    #1;
    chk("i_back_idle", bus.l2_read, 1'b0);
    chk("i_grant_count", i_grant_count, 16'd1);
    tick();
    chk("i_stays_idle", bus.l2_read, 1'b0);

    // contention right after reset: I first, then D
    rst_n = 1'b0; #1; rst_n = 1'b1;
    chk("rst2_i_count", i_grant_count, 16'd0);
    bus.i_read = 1'b1; bus.i_address = 16'h1111;
    bus.d_read = 1'b1; bus.d_address = 16'h2222;
    tick();
    chk("cont_conflict1", conflict_count, 16'd1);
    chk("cont_first_i", bus.l2_address, 16'h1111);
    chk("cont_first_read", bus.l2_read, 1'b1);
    bus.l2_resp = 1'b1;
    #1;
    chk("cont_i_resp", bus.i_resp, 1'b1);
    chk("cont_no_d_resp", bus.d_resp, 1'b0);
    tick();
    bus.i_read = 1'b0; bus.l2_resp = 1'b0;
    #1;
    chk("cont_gap_idle", bus.l2_read, 1'b0);
    tick();
    chk("cont_then_d", bus.l2_address, 16'h2222);
    chk("cont_d_read", bus.l2_read, 1'b1);
    bus.l2_resp = 1'b1;
    #1;
    chk("cont_d_resp", bus.d_resp, 1'b1);
    chk("cont_no_i_resp", bus.i_resp, 1'b0);
    tick();
    bus.d_read = 1'b0; bus.l2_resp = 1'b0;
    #1;
    chk("cont_counts", {i_grant_count, d_grant_count, conflict_count},
        {16'd1, 16'd1, 16'd1});

    // D-cache write-back, request dropped while in flight
    bus.d_write = 1'b1; bus.d_address = 16'h8010; bus.d_wdata = C_WB;
    tick();
    chk("wb_l2_write", bus.l2_write, 1'b1);
    chk("wb_l2_read", bus.l2_read, 1'b0);
    chk("wb_l2_wdata", bus.l2_wdata, C_WB);
    chk("wb_l2_address", bus.l2_address, 16'h8010);
    bus.d_write = 1'b0;
    tick();
    chk("wb_hold_type", bus.l2_write, 1'b1);
    bus.l2_resp = 1'b1;
    #1;
    chk("wb_d_resp", bus.d_resp, 1'b1);
    tick();
    bus.l2_resp = 1'b0;
    #1;
    chk("wb_idle", bus.l2_write, 1'b0);
    chk("wb_d_count", d_grant_count, 16'd2);

    // round robin both ways: last grant D -> I wins, then D wins
    bus.i_read = 1'b1; bus.i_address = 16'h0AA0;
    bus.d_read = 1'b1; bus.d_address = 16'h0DD0;
    tick();
    chk("rr_i_wins", bus.l2_address, 16'h0AA0);
    bus.l2_resp = 1'b1;
    tick();
    bus.l2_resp = 1'b0;
    tick();
    chk("rr_d_wins", bus.l2_address, 16'h0DD0);
    chk("rr_conflict3", conflict_count, 16'd3);
    bus.i_read = 1'b0;
    bus.l2_resp = 1'b1;
    tick();
    bus.d_read = 1'b0; bus.l2_resp = 1'b0;
    #1;
    chk("rr_counts", {i_grant_count, d_grant_count}, {16'd2, 16'd3});

    // reset in the middle of a D transaction, late L2 resp afterwards
    bus.d_read = 1'b1;
    tick();
    chk("mid_l2_read", bus.l2_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_l2_read", bus.l2_read, 1'b0);
    chk("mid_rst_counts", {i_grant_count, d_grant_count, conflict_count}, 48'd0);
    tick();
    rst_n = 1'b1; bus.d_read = 1'b0; bus.l2_resp = 1'b1;
    #1;
    chk("mid_no_d_resp", bus.d_resp, 1'b0);
    chk("mid_no_i_resp", bus.i_resp, 1'b0);
    tick();
    chk("mid_no_d_resp2", bus.d_resp, 1'b0);
    bus.l2_resp = 1'b0;

    // saturation then count_reset winning over an increment
    force dut.r_d_grant_cnt = 16'hFFFF;
    #1;
    release dut.r_d_grant_cnt;
    #1;
    chk("sat_preload", d_grant_count, 16'hFFFF);
    bus.d_read = 1'b1;
    tick();
    bus.l2_resp = 1'b1;
    tick();
    bus.d_read = 1'b0; bus.l2_resp = 1'b0;
    #1;
    chk("sat_hold", d_grant_count, 16'hFFFF);
    bus.d_read = 1'b1;
    tick();
    bus.l2_resp = 1'b1; count_reset = 1'b1;
    tick();
    bus.d_read = 1'b0; bus.l2_resp = 1'b0; count_reset = 1'b0;
    #1;
    chk("sat_clear", d_grant_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter LINE_WIDTH, default 128, SHALL set the cache line data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the byte address width in bits.
REQ-003 clk  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_read  input  1  SHALL be the I-cache line-read request (the I-cache never writes).
REQ-006 i_address  input  ADDR_WIDTH  SHALL be the I-cache line address.
REQ-007 i_rdata  output  LINE_WIDTH  SHALL return the line to the I-cache.
REQ-008 i_resp  output  1  SHALL signal I-cache completion.
REQ-009 d_read, d_write  input  1 each  SHALL be the D-cache line read and write-back requests.
REQ-010 d_address  input  ADDR_WIDTH  SHALL be the D-cache line address.
REQ-011 d_wdata  input  LINE_WIDTH  SHALL be the D-cache write-back line.
REQ-012 d_rdata  output  LINE_WIDTH  SHALL return the line to the D-cache.
REQ-013 d_resp  output  1  SHALL signal D-cache completion.
REQ-014 l2_read, l2_write  output  1 each  SHALL be the downstream L2 requests.
REQ-015 l2_address  output  ADDR_WIDTH  SHALL be the downstream address.
REQ-016 l2_wdata  output  LINE_WIDTH  SHALL be the downstream write data.
REQ-017 l2_rdata  input  LINE_WIDTH  SHALL be the downstream read data.
REQ-018 l2_resp  input  1  SHALL be the downstream completion.
REQ-019 i_grant_count, d_grant_count, conflict_count  output  16 each  SHALL be the performance counters.
REQ-020 count_reset  input  1  SHALL synchronously clear all three counters.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D.
REQ-022 In IDLE, l2_read, l2_write, i_resp and d_resp SHALL all be 0, and no downstream request SHALL be driven.
REQ-023 IDLE transitions:
  - I-cache only requesting: next state SERVE_I.
  - D-cache only requesting (d_read|d_write): next state SERVE_D.
  - Neither requesting: remain in IDLE.
REQ-024 When both request in IDLE, the arbiter SHALL grant the requester not recorded in last_grant (round-robin).
REQ-025 last_grant SHALL update on every IDLE-to-SERVE transition.
REQ-026 In SERVE_I, the downstream signals SHALL be: l2_read=1, l2_write=0, l2_address=i_address.
REQ-027 In SERVE_I, on l2_resp: i_resp=l2_resp in the same cycle, and the FSM SHALL return to IDLE.
REQ-028 In SERVE_D, the downstream signals SHALL be:
  - l2_write=d_write.
  - l2_read=d_read&~d_write (write has priority if both are asserted).
  - l2_address=d_address, l2_wdata=d_wdata.
REQ-029 In SERVE_D, on l2_resp: d_resp=l2_resp in the same cycle, and the FSM SHALL return to IDLE.
REQ-030 A SERVE state SHALL hold until l2_resp and SHALL NOT preempt, even if the other requester asserts.
REQ-031 i_rdata and d_rdata SHALL both be driven combinationally from l2_rdata at all times; validity is indicated only by the matching resp.
REQ-032 The non-granted requester's resp SHALL be 0 in every cycle.
REQ-033 Arbitration latency: a request first seen in IDLE SHALL reach L2 in the following cycle.
REQ-034 Back-to-back service of the same requester SHALL include at least one IDLE cycle after each resp, so a request held for one cycle after resp is not re-issued.
REQ-035 If the requester drops its request while in SERVE before l2_resp, the arbiter SHALL keep driving the latched request type and SHALL return to IDLE on l2_resp.
REQ-036 Counter increments:
  - i_grant_count SHALL increment on the SERVE_I cycle with l2_resp=1.
  - d_grant_count SHALL increment on the SERVE_D cycle with l2_resp=1.
  - conflict_count SHALL increment on every IDLE cycle in which both requesters are asserting.
REQ-037 Counters SHALL saturate at 16'hFFFF, and count_reset SHALL take priority over increment.

Reset
REQ-038 rst_n=0 SHALL immediately (asynchronously) force: state=IDLE, last_grant=D, all three counters=0.
REQ-039 Consequently, l2_read=l2_write=i_resp=d_resp=0 during reset, including when reset is asserted mid-transaction.
REQ-040 The first contested grant after reset SHALL go to the I-cache.
REQ-041 An in-flight L2 transaction aborted by reset SHALL NOT produce a resp to either requester after rst_n deasserts.

Verification
REQ-042 Single I-cache read:
  - Stimulus: i_read=1, i_address=16'h3040, L2 returns l2_resp after 4 cycles with l2_rdata=128'hA5..A5.
  - Response: l2_read=1 with l2_address=16'h3040 from cycle 1; i_resp=1 with i_rdata=A5..A5 in the l2_resp cycle; i_grant_count=1.
REQ-043 Contention after reset:
  - Stimulus: i_read and d_read asserted in the same cycle.
  - Response: SERVE_I first, then IDLE, then SERVE_D; conflict_count=1; d_resp never asserted during SERVE_I.
REQ-044 D-cache write-back:
  - Stimulus: d_write=1, d_address=16'h8010, d_wdata=128'h1234...
  - Response: l2_write=1, l2_read=0, l2_wdata matches d_wdata; d_resp on l2_resp.
REQ-045 Reset mid-operation:
  - Stimulus: rst_n=0 pulsed during SERVE_D, then l2_resp=1 arrives after rst_n deasserts.
  - Response: outputs go to 0 immediately on reset; counters=0; no d_resp.
REQ-046 Counter saturation:
  - Stimulus: force d_grant_count to 16'hFFFF, complete one more D transaction, then assert count_reset and a completion in the same cycle.
  - Response: d_grant_count stays FFFF, then reads 0 after the count_reset cycle.
